// File: rtl/multdiv_unit.sv
// Iterative signed 32x32 multiply / divide; 33-edge fixed latency from start to result.
// A new start in any state restarts the unit; no backpressure, result is held until the next start or reset.
module multdiv_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        start;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [4:0]  cnt;
    logic        fin;
    logic        neg;
    logic        div_zero;
    logic [63:0] acc;
    logic [63:0] op_a;
    logic [31:0] op_b;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [63:0] prod_s;
    logic [31:0] quot_s;

    assign start = ctrl_MULT ^ ctrl_DIV;
    assign mag_a = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    assign mag_b = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;

    // Restoring-division step: shift the next dividend bit into the partial remainder.
    assign shifted = {acc[31:0], op_b[31]};
    assign diff    = shifted - {1'b0, op_a[31:0]};

    assign prod_s = neg ? (64'd0 - acc) : acc;
    assign quot_s = neg ? (32'd0 - op_b) : op_b;

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ctrl_MULT ? MULT : DIV;
        end else begin
            case (state)
                MULT, DIV: if (fin) state_nxt = DONE;
                DONE:      state_nxt = IDLE;
                default:   state_nxt = state;
            endcase
        end
    end

    always_comb begin
        busy           = (state == MULT) || (state == DIV);
        data_resultRDY = (state == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt            <= 5'd0;
            fin            <= 1'b0;
            neg            <= 1'b0;
            div_zero       <= 1'b0;
            acc            <= 64'd0;
            op_a           <= 64'd0;
            op_b           <= 32'd0;
            data_result    <= 32'd0;
            data_exception <= 1'b0;
        end else if (start) begin
            cnt      <= 5'd0;
            fin      <= 1'b0;
            neg      <= data_operandA[31] ^ data_operandB[31];
            div_zero <= (data_operandB == 32'd0);
            acc      <= 64'd0;
            // Multiply: op_a = shifting multiplicand, op_b = shifting multiplier.
            // Divide:   op_a = fixed divisor, op_b = dividend shifting out / quotient shifting in.
            if (ctrl_MULT) begin
                op_a <= {32'd0, mag_a};
                op_b <= mag_b;
            end else begin
                op_a <= {32'd0, mag_b};
                op_b <= mag_a;
            end
        end else if ((state == MULT) || (state == DIV)) begin
            if (!fin) begin
                cnt <= cnt + 5'd1;
                if (cnt == 5'd31) fin <= 1'b1;
                if (state == MULT) begin
                    acc  <= acc + (op_b[0] ? op_a : 64'd0);
                    op_a <= op_a << 1;
                    op_b <= op_b >> 1;
                end else if (!diff[32]) begin
                    acc  <= {32'd0, diff[31:0]};
                    op_b <= {op_b[30:0], 1'b1};
                end else begin
                    acc  <= {32'd0, shifted[31:0]};
                    op_b <= {op_b[30:0], 1'b0};
                end
            end else if (state == MULT) begin
                data_result    <= prod_s[31:0];
                data_exception <= !((&prod_s[63:31]) || !(|prod_s[63:31]));
            end else if (div_zero) begin
                data_result    <= 32'd0;
                data_exception <= 1'b1;
            end else begin
                // Only MIN / -1 yields a positive quotient with bit 31 set.
                data_result    <= quot_s;
                data_exception <= !neg && op_b[31];
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Randomised and directed checks of multdiv_unit against a plain-arithmetic reference model.
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data_operandA = 32'd0;
    logic [31:0] data_operandB = 32'd0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int n_pass = 0;
    int n_total = 0;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference: signed arithmetic on 64-bit integers.
    function automatic void ref_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] res, output logic exc);
        longint sa, sb, p, q;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        if (!is_div) begin
            p   = sa * sb;
            res = p[31:0];
            exc = (p != longint'(signed'(p[31:0])));
        end else if (sb == 0) begin
            res = 32'd0;
            exc = 1'b1;
        end else begin
            q   = sa / sb;
            res = q[31:0];
            exc = (q != longint'(signed'(q[31:0])));
        end
    endfunction

    // Caller is at a negedge; drives one start across the next posedge.
    task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = !is_div;
        ctrl_DIV      = is_div;
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Waits for the strobe with a cycle budget; ends at the negedge where RDY is seen.
    task automatic wait_done(input string tag, input logic [31:0] exp_res, input logic exp_exc,
                             input bit check_after);
        int k = 0;
        bit busy_ok = 1'b1;
        while (!data_resultRDY && k < 40) begin
            if (k > 0 && !busy) busy_ok = 1'b0;
            @(negedge clock);
            k++;
        end
        chk({tag, "_latency"}, k, 33);
        chk({tag, "_busy_during"}, busy_ok, 1);
        chk({tag, "_result"}, data_result, exp_res);
        chk({tag, "_exception"}, data_exception, exp_exc);
        if (check_after) begin
            @(negedge clock);
            chk({tag, "_rdy_one_cycle"}, data_resultRDY, 0);
            chk({tag, "_busy_after"}, busy, 0);
            chk({tag, "_result_held"}, data_result, exp_res);
        end
    endtask

    task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, input bit check_after);
        logic [31:0] r;
        logic        e;
        ref_op(is_div, a, b, r, e);
        start_op(is_div, a, b);
        wait_done(tag, r, e, check_after);
    endtask

    initial begin
        int rdy_seen;
        logic [31:0] held_res;
        logic        held_exc;
        logic [31:0] ra, rb;
        bit          rdiv;

        repeat (3) @(negedge clock);
        chk("reset_result", data_result, 0);
        chk("reset_exception", data_exception, 0);
        chk("reset_rdy", data_resultRDY, 0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        @(negedge clock);

        run_op("mul_7_m3", 0, 32'd7, 32'hFFFFFFFD, 1);
        run_op("mul_ovf_16", 0, 32'h00010000, 32'h00010000, 1);
        run_op("mul_min_m1", 0, 32'h80000000, 32'hFFFFFFFF, 1);
        run_op("div_m7_2", 1, 32'hFFFFFFF9, 32'd2, 1);
        run_op("div_5_0", 1, 32'd5, 32'd0, 1);
        run_op("div_min_m1", 1, 32'h80000000, 32'hFFFFFFFF, 1);

        // Abort: DIV issued 10 edges after a MULT must yield only the DIV result.
        start_op(0, 32'd3, 32'd4);
        rdy_seen = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        chk("abort_no_early_rdy", rdy_seen, 0);
        run_op("abort_div_100_7", 1, 32'd100, 32'd7, 1);

        // Reset mid-operation discards the operation.
        start_op(0, 32'd9, 32'd9);
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("midreset_busy", busy, 0);
        chk("midreset_result", data_result, 0);
        chk("midreset_exception", data_exception, 0);
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY) rdy_seen++;
        end
        chk("midreset_no_rdy", rdy_seen, 0);

        // Both controls high together: ignored.
        run_op("pre_both", 0, 32'hFFFFFFFF, 32'd5, 1);
        held_res = data_result;
        held_exc = data_exception;
        data_operandA = 32'd1;
        data_operandB = 32'd1;
        ctrl_MULT = 1'b1;
        ctrl_DIV  = 1'b1;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        chk("both_busy", busy, 0);
        rdy_seen = 0;
        repeat (40) begin
            @(negedge clock);
            if (data_resultRDY || busy) rdy_seen++;
        end
        chk("both_no_activity", rdy_seen, 0);
        chk("both_result_held", data_result, held_res);
        chk("both_exception_held", data_exception, held_exc);

        // Start accepted in the DONE cycle (check_after=0 leaves us there).
        run_op("done_first", 0, 32'd6, 32'd7, 0);
        run_op("done_restart", 1, 32'hFFFFFF9C, 32'd7, 1);

        for (int i = 0; i < 24; i++) begin
            rdiv = $urandom_range(0, 1);
            ra   = $urandom;
            case ($urandom_range(0, 3))
                0: rb = $urandom;
                1: rb = $urandom_range(0, 300);
                2: rb = 32'd0 - $urandom_range(0, 300);
                default: rb = (i % 2 == 0) ? 32'd0 : 32'hFFFFFFFF;
            endcase
            if (i % 5 == 0) ra = 32'h80000000;
            if (i % 3 == 0) ra = ra >>> $urandom_range(8, 24);
            run_op("rand", rdiv, ra, rb, (i % 4) != 3);
        end
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 clock  in  1  master clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 data_operandA  in  32  signed multiplicand / dividend, sampled only on a start edge.
REQ-005 data_operandB  in  32  signed multiplier / divisor, sampled only on a start edge.
REQ-006 ctrl_MULT  in  1  single-cycle start pulse for multiply.
REQ-007 ctrl_DIV  in  1  single-cycle start pulse for divide.
REQ-008 data_result  out  32  registered result, valid from the data_resultRDY cycle until the next accepted start or reset.
REQ-009 data_exception  out  1  registered error flag, valid and held exactly like data_result.
REQ-010 data_resultRDY  out  1  one-cycle completion strobe.
REQ-011 busy  out  1  high while an operation is in progress, IDLE/DONE low.

Function
REQ-012 FSM states SHALL be IDLE, MULT, DIV, DONE; reset forces IDLE from any state.
REQ-013 A start SHALL be accepted on an edge where exactly one of ctrl_MULT/ctrl_DIV is 1, in any state; operands are latched and the 5-bit iteration counter is cleared on that edge.
REQ-014 Both ctrl_MULT and ctrl_DIV high on the same edge SHALL be ignored: no start, state unchanged.
REQ-015 A start accepted while in MULT or DIV SHALL abort the current operation silently (no data_resultRDY for it) and restart with the new operands.
REQ-016 MULT/DIV SHALL perform one iteration per cycle for exactly 32 cycles, then enter DONE.
REQ-017 Latency: start accepted at edge N -> data_resultRDY high during the cycle after edge N+33, for exactly one cycle; DONE returns to IDLE on the next edge unless a new start is accepted.
REQ-018 Latency SHALL be fixed at 33 edges for all operand values, including divide-by-zero.
REQ-019 Multiply: signed 32x32 (shift-add or radix-2 Booth) into a 64-bit product; data_result = product[31:0].
REQ-020 Multiply exception = 1 iff product[63:31] is not all-zeros or all-ones (e.g. 0x80000000 x 0xFFFFFFFF -> result 0x80000000, exception 1).
REQ-021 Divide: signed, quotient truncated toward zero, computed on magnitudes with sign fixed in DONE; remainder discarded.
REQ-022 Divide by zero: data_result = 0x00000000, data_exception = 1.
REQ-023 Divide 0x80000000 / 0xFFFFFFFF: data_result = 0x80000000, data_exception = 1.
REQ-024 data_result and data_exception SHALL update only on the edge entering DONE and on reset; they SHALL NOT show intermediate values.
REQ-025 busy SHALL be 1 in MULT and DIV and rise on the edge after the start edge.
REQ-026 A start accepted on the same edge DONE is exited SHALL be honoured normally.

Reset
REQ-027 On reset: state IDLE, data_result = 0, data_exception = 0, data_resultRDY = 0, busy = 0, counter = 0.
REQ-028 Reset SHALL take priority over a start on the same edge.
REQ-029 Reset mid-operation SHALL discard the operation with no data_resultRDY pulse.

Verification
REQ-030 MULT 7 x 0xFFFFFFFD (-3) -> 33 edges later result 0xFFFFFFEB, exception 0, RDY exactly one cycle, busy 0 after.
REQ-031 MULT 0x00010000 x 0x00010000 -> result 0x00000000, exception 1.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> result 0xFFFFFFFD (-3), exception 0; DIV 5 / 0 -> result 0, exception 1, still 33-edge latency.
REQ-033 MULT 3 x 4 started, DIV 100 / 7 issued 10 edges later -> single RDY 33 edges after the DIV start, result 14, exception 0.
REQ-034 MULT started, reset asserted 5 edges later -> busy 0, outputs 0, no RDY within the next 40 cycles.
REQ-035 ctrl_MULT and ctrl_DIV high together in IDLE -> busy stays 0, no RDY, outputs unchanged.
